// File: rtl/aes_plat_pkg.sv
// Shared definitions for the AES verification platform run sequencer.
// Holds the sequencer state encoding and the default counter width.
package aes_plat_pkg;

    localparam int unsigned CNT_W_DFLT = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WARMUP = 3'd1,
        ST_RUN    = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/seq_watchdog.sv
// Loadable saturating counter: counts down to TERM or up to TERM, then holds.
// Used both as the warm-up delay and as the result-timeout watchdog.
module seq_watchdog #(
    parameter int unsigned    W          = 32,
    parameter bit             COUNT_DOWN = 1'b1,
    parameter logic [W-1:0]   TERM       = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expire = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !expire) begin
            cnt_d = COUNT_DOWN ? (cnt_q - ONE) : (cnt_q + ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/aes_test_seq.sv
// Run-level sequencer: warm-up, block issue, result drain with watchdog, and
// pass/fail/timeout reporting against scoreboard totals.
module aes_test_seq
    import aes_plat_pkg::*;
#(
    parameter int unsigned WARMUP_CYC  = 4096,
    parameter int unsigned TIMEOUT_CYC = 1_000_000,
    parameter int unsigned CNT_W       = CNT_W_DFLT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode_enc,
    input  logic [CNT_W-1:0] num_blocks,
    input  logic             tx_require,
    input  logic [CNT_W-1:0] total,
    input  logic [CNT_W-1:0] correct,
    output logic             work,
    output logic             enc,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] issued,
    output logic [CNT_W-1:0] fail_cnt
);

    localparam int unsigned      WD_W = 32;
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    seq_state_e       state_q, state_d;
    logic             work_q, work_d, enc_q, enc_d, busy_q, busy_d, done_q, done_d;
    logic             pass_q, pass_d, timeout_q, timeout_d;
    logic [CNT_W-1:0] issued_q, issued_d, fail_q, fail_d, num_q, num_d;
    logic [CNT_W-1:0] base_total_q, base_total_d, base_correct_q, base_correct_d;
    logic [CNT_W-1:0] total_prev_q;
    logic [CNT_W-1:0] res, ok;
    logic             active, start_ok, warm_exp, wd_en, wd_clr, wd_exp;

    // Modular deltas keep the run correct when scoreboard counters wrap.
    assign res      = total - base_total_q;
    assign ok       = correct - base_correct_q;
    assign active   = state_q inside {ST_WARMUP, ST_RUN, ST_DRAIN};
    assign start_ok = start && !abort && (state_q inside {ST_IDLE, ST_DONE});
    assign wd_en    = state_q inside {ST_RUN, ST_DRAIN};
    assign wd_clr   = !wd_en || (total != total_prev_q);

    seq_watchdog #(
        .W          (WD_W),
        .COUNT_DOWN (1'b1),
        .TERM       ('0)
    ) u_warm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (1'b0),
        .load     (start_ok),
        .load_val (WD_W'(WARMUP_CYC - 1)),
        .en       (state_q == ST_WARMUP),
        .expire   (warm_exp)
    );

    seq_watchdog #(
        .W          (WD_W),
        .COUNT_DOWN (1'b0),
        .TERM       (WD_W'(TIMEOUT_CYC - 1))
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wd_clr),
        .load     (1'b0),
        .load_val ('0),
        .en       (wd_en),
        .expire   (wd_exp)
    );

    // NOTE: every next-state signal takes its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        work_d         = work_q;
        enc_d          = enc_q;
        pass_d         = pass_q;
        timeout_d      = timeout_q;
        issued_d       = issued_q;
        fail_d         = fail_q;
        num_d          = num_q;
        base_total_d   = base_total_q;
        base_correct_d = base_correct_q;

        if (active) begin
            if (tx_require) begin
                issued_d = issued_q + ONE;
            end
            fail_d = res - ok;
        end

        if (abort) begin
            state_d   = ST_IDLE;
            work_d    = 1'b0;
            pass_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_ok) begin
                        enc_d          = mode_enc;
                        num_d          = num_blocks;
                        base_total_d   = total;
                        base_correct_d = correct;
                        issued_d       = '0;
                        fail_d         = '0;
                        timeout_d      = 1'b0;
                        pass_d         = (num_blocks == '0);
                        state_d        = (num_blocks == '0) ? ST_DONE : ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (warm_exp) begin
                        state_d = ST_RUN;
                        work_d  = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (issued_d >= num_q) begin
                        state_d = ST_DRAIN;
                        work_d  = 1'b0;
                    end else if (wd_exp) begin
                        state_d   = ST_DONE;
                        work_d    = 1'b0;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // A late block in the completion cycle defers the decision.
                    if (!tx_require && (res >= issued_q)) begin
                        state_d   = ST_DONE;
                        pass_d    = (res == issued_q) && (res == ok);
                        timeout_d = 1'b0;
                    end else if (wd_exp) begin
                        state_d   = ST_DONE;
                        pass_d    = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    work_d  = 1'b0;
                end
            endcase
        end

        busy_d = state_d inside {ST_WARMUP, ST_RUN, ST_DRAIN};
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            work_q         <= 1'b0;
            enc_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
            timeout_q      <= 1'b0;
            issued_q       <= '0;
            fail_q         <= '0;
            num_q          <= '0;
            base_total_q   <= '0;
            base_correct_q <= '0;
            total_prev_q   <= '0;
        end else begin
            state_q        <= state_d;
            work_q         <= work_d;
            enc_q          <= enc_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
            timeout_q      <= timeout_d;
            issued_q       <= issued_d;
            fail_q         <= fail_d;
            num_q          <= num_d;
            base_total_q   <= base_total_d;
            base_correct_q <= base_correct_d;
            total_prev_q   <= total;
        end
    end

    assign work     = work_q;
    assign enc      = enc_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign timeout  = timeout_q;
    assign issued   = issued_q;
    assign fail_cnt = fail_q;

endmodule

// File: doc/aes_test_seq.md
Name: aes_test_seq

Overview:
- Run-level sequencer for the AES verification platform.
- Replaces the static work/enc switch inputs that drive the data generator.
- On a start pulse it waits for the chip to come out of reset, asserts work with the selected direction, and counts blocks handed to the AES transmitter until the programmed block count is reached.
- It then drains outstanding results, watching scoreboard totals with a watchdog, and reports done, pass, fail count and timeout.

Parameters:
- WARMUP_CYC, 4096, clk cycles between start and work assertion (covers chip reset release and clock settling).
- TIMEOUT_CYC, 1_000_000, max clk cycles without a scoreboard total increment while results are outstanding.
- CNT_W, 32, width of block and result counters (matches scoreboard total/correct).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a run. Ignored unless in IDLE or DONE.
- abort  input  1  one-cycle pulse; from any state go to IDLE, work=0.
- mode_enc  input  1  direction for the run; sampled on start.
- num_blocks  input  CNT_W  blocks to issue; sampled on start. 0 means complete immediately.
- tx_require  input  1  one-cycle pulse per block popped from the generator data FIFO by the AES transmitter.
- total  input  CNT_W  scoreboard cumulative total.
- correct  input  CNT_W  scoreboard cumulative correct.
- work  output  1  generator enable.
- enc  output  1  generator direction.
- busy  output  1  high in WARMUP, RUN, DRAIN.
- done  output  1  level; high in DONE.
- pass  output  1  valid when done.
- timeout  output  1  valid when done; watchdog expired.
- issued  output  CNT_W  blocks issued this run.
- fail_cnt  output  CNT_W  mismatches this run.

Behaviour:
- All outputs are registered. Reset value of every output is 0, state IDLE.
- Baselines: on accepted start, latch base_total=total and base_correct=correct, and clear issued.
- Deltas: res = total-base_total and ok = correct-base_correct, both mod 2^CNT_W, so counter wrap is tolerated. fail_cnt = res-ok, registered.
- IDLE/DONE:
  - start -> WARMUP; load warm counter with WARMUP_CYC-1; latch enc=mode_enc.
  - If num_blocks==0, go directly to DONE with pass=1 and timeout=0.
  - In DONE, done, pass, timeout, issued and fail_cnt hold until the next start or abort.
- WARMUP:
  - Decrement the counter each cycle. At 0 -> RUN; work=1 from the first RUN cycle.
  - tx_require pulses in WARMUP are counted into issued.
- RUN:
  - Each tx_require increments issued.
  - When a pulse makes issued==num_blocks: work=0 on the next cycle, and -> DRAIN.
  - Pulses arriving after that (generator prefetch) are still counted; issued may exceed num_blocks.
- DRAIN:
  - Complete when res >= issued -> DONE, pass = (fail_cnt==0) and timeout=0.
  - If res > issued (spurious results), go to DONE with pass=0.
- Watchdog:
  - Active in RUN and DRAIN. Reloaded to 0 whenever total changes (compare against the registered previous total) and on entry to RUN.
  - On reaching TIMEOUT_CYC-1 -> DONE with timeout=1, pass=0, work=0.
- Simultaneous events:
  - abort has priority over all other transitions.
  - start together with abort is ignored.
  - A tx_require arriving in the same cycle as a DRAIN completion is counted; completion is re-evaluated next cycle, so DONE is not entered that cycle.
- Mid-operation:
  - Async reset mid-run clears everything immediately; work falls asynchronously.
  - abort clears busy and done and preserves issued/fail_cnt for debug.
- enc is constant for the whole run and changes only on an accepted start.

Decomposition:
- Shared package aes_plat_pkg holds:
  - state encoding constants ST_IDLE, ST_WARMUP, ST_RUN, ST_DRAIN, ST_DONE;
  - CNT_W default.
- One sub-module, seq_watchdog: a loadable down/up counter with clear, enable and expire outputs. It is reused for the WARMUP delay and the timeout, instantiated twice.

Test Plan:
- Nominal run: WARMUP_CYC=16, num_blocks=10, mode_enc=1, 10 tx_require pulses, scoreboard total and correct each +10 -> work high from start+17 for the duration of RUN, issued=10, done=1, pass=1, fail_cnt=0, enc=1.
- Mismatch: num_blocks=4, total +4, correct +3 -> done=1, pass=0, fail_cnt=1.
- Timeout: TIMEOUT_CYC=100, num_blocks=3, only 2 results arrive -> done=1, timeout=1, pass=0, exactly 100 cycles after the last total change.
- Wrap and prefetch: base total=32'hFFFF_FFFE, num_blocks=4, 5 tx_require pulses with 5 results -> issued=5, res=5 across the wrap, pass=1.
- Abort and restart: abort in RUN after 2 blocks -> work=0 next cycle, busy=0; then start with num_blocks=0 -> done=1, pass=1 the cycle after start.
- Reset mid-DRAIN: rst_n low -> all outputs 0 and state IDLE; start pulses during busy are ignored.
